etapa_if: RTL and testbench
===========================

# etapa_if

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Holds the program counter, selects the next PC (sequential, branch, jump, jump-register), reads the instruction memory combinationally, and produces PC+4, PC+8 and the fetched word for IF/ID to latch. It also owns the program-load write port used by the debug unit, and a halt state machine that freezes fetch when the HALT word is fetched.

## Interface
- NBITS, 32, datapath/PC width
- IMEM_DEPTH, 256, instruction memory depth in words (power of two)
- IMEM_ABITS, 8, log2(IMEM_DEPTH)

Ports (all widths NBITS unless stated):
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_PC_Write  in  1  hazard unit enable; 0 = stall, PC holds
- i_Step  in  1  debug step enable; PC advances only when 1
- i_Branch  in  1  taken branch from ID
- i_Branch_Addr  in  NBITS  branch target
- i_Jump  in  1  J/JAL from ID
- i_Jump_Addr  in  NBITS  jump target
- i_JumpReg  in  1  JR/JALR from ID
- i_JR_Addr  in  NBITS  register target
- i_Mem_Wr_En  in  1  debug program-load write strobe
- i_Mem_Wr_Addr  in  IMEM_ABITS  word address
- i_Mem_Wr_Data  in  NBITS  instruction word to store
- o_PC  out  NBITS  current PC
- o_PC4  out  NBITS  PC+4
- o_PC8  out  NBITS  PC+8
- o_Instruction  out  NBITS  fetched instruction (or NOP when halted)
- o_Halted  out  1  fetch halted

## Operation
- advance = i_PC_Write & i_Step & (state == RUN).
- Next-PC priority: i_JumpReg > i_Jump > i_Branch > PC+4. Only evaluated when advance=1; otherwise PC holds regardless of redirect inputs.
- o_PC4 = PC+4, o_PC8 = PC+8, combinational, modulo 2^NBITS (wrap at 0xFFFFFFFC -> 0).
- Instruction read: combinational, index = PC[IMEM_ABITS+1:2]; PC[1:0] and bits above IMEM_ABITS+1 ignored (address wraps within memory).
- Memory write: synchronous on i_clk when i_Mem_Wr_En=1, independent of state, stall, step and reset. Memory contents are NOT cleared by i_reset (loaded program survives reset).
- Halt FSM, states RUN, HALT:
  - RUN -> HALT at the edge where advance=1 and fetched word == HALT_WORD (32'hFFFFFFFF). PC still advances to PC+4 on that edge.
  - HALT: PC frozen; o_Instruction forced to NOP (32'h00000000); o_Halted=1. Exit only through i_reset.
  - Stalled HALT_WORD (advance=0) does not trigger the transition.
- In RUN, o_Instruction = memory word, including HALT_WORD itself, so the halt propagates into IF/ID.

## Timing
- Reset (asynchronous): PC=0, state=RUN, o_PC4=4, o_PC8=8, o_Halted=0, o_Instruction=mem[0] (combinational).
- PC update latency: 1 cycle; redirect sampled at edge k appears on o_PC after edge k.
- Fetch latency: 0 cycles from PC to o_Instruction; IF/ID captures it on the same edge the PC advances.
- Write-then-read same address: new word visible on o_Instruction after the write edge.
- o_Halted asserts after the edge that fetched HALT_WORD; o_Instruction reads NOP from then on.
- Reset mid-operation: immediate return to reset values, state RUN; memory unaffected.

## Structure
- Shared package: HALT_WORD, NOP_WORD, PC increment constant (4), RUN/HALT state encoding.
- One sub-module: memoria_instrucciones (IMEM_DEPTH x NBITS, async read, sync write). PC register, next-PC mux and halt FSM in the top.

## Test plan
- Reset, load mem[0..3]=0x20010001,0x20020002,0x20030003,0xFFFFFFFF, run with PC_Write=Step=1 -> o_PC 0,4,8,12; o_Halted=1 after 4th edge, o_PC=16 held, o_Instruction=0.
- i_Step=0 for 3 cycles at PC=8 -> PC stays 8, o_Instruction unchanged; Step=1 -> PC=12.
- Simultaneous i_JumpReg(0x40), i_Jump(0x80), i_Branch(0xC0) -> PC=0x40; Jump+Branch -> 0x80; i_PC_Write=0 with Branch -> PC holds.
- PC redirected to 0xFFFFFFFC -> o_PC4=0, o_PC8=4; index wraps to mem[255].
- i_reset pulsed while halted at PC=16 -> PC=0, o_Halted=0, o_Instruction=mem[0] (program intact).
- Write mem[2]=0x12345678 while PC=8 -> o_Instruction=0x12345678 after write edge.

Source files
------------

// File: rtl/etapa_if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Halt/NOP encodings, PC increment and halt FSM states.
package etapa_if_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } if_state_t;

endpackage

// File: rtl/etapa_if_memoria_instrucciones.sv
// Instruction memory: asynchronous read, synchronous write.
// Contents are intentionally not reset so a loaded program survives.
module memoria_instrucciones #(
  parameter int NBITS      = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int IMEM_ABITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_Wr_En,
  input  logic [IMEM_ABITS-1:0] i_Wr_Addr,
  input  logic [NBITS-1:0]      i_Wr_Data,
  input  logic [IMEM_ABITS-1:0] i_Rd_Addr,
  output logic [NBITS-1:0]      o_Rd_Data
);

  logic [NBITS-1:0] r_mem [IMEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_Wr_En) begin
      r_mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = r_mem[i_Rd_Addr];

endmodule

// File: rtl/etapa_if.sv
// MIPS instruction-fetch stage: PC register, next-PC select,
// instruction memory and the fetch halt state machine.
module etapa_if
  import etapa_if_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int IMEM_ABITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_PC_Write,
  input  logic                  i_Step,
  input  logic                  i_Branch,
  input  logic [NBITS-1:0]      i_Branch_Addr,
  input  logic                  i_Jump,
  input  logic [NBITS-1:0]      i_Jump_Addr,
  input  logic                  i_JumpReg,
  input  logic [NBITS-1:0]      i_JR_Addr,
  input  logic                  i_Mem_Wr_En,
  input  logic [IMEM_ABITS-1:0] i_Mem_Wr_Addr,
  input  logic [NBITS-1:0]      i_Mem_Wr_Data,
  output logic [NBITS-1:0]      o_PC,
  output logic [NBITS-1:0]      o_PC4,
  output logic [NBITS-1:0]      o_PC8,
  output logic [NBITS-1:0]      o_Instruction,
  output logic                  o_Halted
);

  logic [NBITS-1:0] r_pc;
  if_state_t        r_state;

  logic [NBITS-1:0] w_pc4;
  logic [NBITS-1:0] w_pc8;
  logic [NBITS-1:0] w_pc_next;
  logic [NBITS-1:0] w_mem_word;
  logic             w_advance;
  logic             w_is_halt;

  assign w_pc4 = r_pc + NBITS'(PC_INC);
  assign w_pc8 = w_pc4 + NBITS'(PC_INC);

  memoria_instrucciones #(
    .NBITS      (NBITS),
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_ABITS (IMEM_ABITS)
  ) u_imem (
    .i_clk     (i_clk),
    .i_Wr_En   (i_Mem_Wr_En),
    .i_Wr_Addr (i_Mem_Wr_Addr),
    .i_Wr_Data (i_Mem_Wr_Data),
    .i_Rd_Addr (r_pc[IMEM_ABITS+1:2]),
    .o_Rd_Data (w_mem_word)
  );

  assign w_advance = i_PC_Write & i_Step & (r_state == ST_RUN);
  assign w_is_halt = (w_mem_word == NBITS'(HALT_WORD));

  // Redirect priority: register jump, then jump, then branch.
  always_comb begin
    w_pc_next = w_pc4;
    priority case (1'b1)
      i_JumpReg: w_pc_next = i_JR_Addr;
      i_Jump:    w_pc_next = i_Jump_Addr;
      i_Branch:  w_pc_next = i_Branch_Addr;
      default:   w_pc_next = w_pc4;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else if (w_advance) begin
      r_pc <= w_pc_next;
      if (w_is_halt) begin
        r_state <= ST_HALT;
      end
    end
  end

  assign o_PC          = r_pc;
  assign o_PC4         = w_pc4;
  assign o_PC8         = w_pc8;
  assign o_Halted      = (r_state == ST_HALT);
  assign o_Instruction = o_Halted ? NBITS'(NOP_WORD) : w_mem_word;

endmodule

// File: tb/tb_etapa_if.sv
// Directed self-checking bench for the instruction-fetch stage.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_etapa_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wr;
  logic        step;
  logic        br;
  logic [31:0] br_addr;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        jr;
  logic [31:0] jr_addr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc8;
  logic [31:0] instr;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  etapa_if #(
    .NBITS      (32),
    .IMEM_DEPTH (256),
    .IMEM_ABITS (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_PC_Write    (pc_wr),
    .i_Step        (step),
    .i_Branch      (br),
    .i_Branch_Addr (br_addr),
    .i_Jump        (jmp),
    .i_Jump_Addr   (jmp_addr),
    .i_JumpReg     (jr),
    .i_JR_Addr     (jr_addr),
    .i_Mem_Wr_En   (wr_en),
    .i_Mem_Wr_Addr (wr_addr),
    .i_Mem_Wr_Data (wr_data),
    .o_PC          (pc),
    .o_PC4         (pc4),
    .o_PC8         (pc8),
    .o_Instruction (instr),
    .o_Halted      (halted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic set_ctl(input logic w, input logic s);
    @(negedge clk);
    pc_wr = w;
    step  = s;
    jr = 1'b0;
    jmp = 1'b0;
    br = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc_wr = 1'b0;
    step = 1'b0;
    br = 1'b0;
    jmp = 1'b0;
    jr = 1'b0;
    br_addr = '0;
    jmp_addr = '0;
    jr_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Fill with harmless words, then the test program, under reset.
    for (int i = 0; i < 256; i++) mem_wr(8'(i), 32'(i));
    mem_wr(8'd0, 32'h2001_0001);
    mem_wr(8'd1, 32'h2002_0002);
    mem_wr(8'd2, 32'h2003_0003);
    mem_wr(8'd3, 32'hFFFF_FFFF);
    mem_wr(8'd255, 32'hDEAD_BEEF);

    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_pc8", pc8, 32'h8);
    check("rst_halt", {31'b0, halted}, 32'h0);
    check("rst_instr", instr, 32'h2001_0001);

    @(negedge clk);
    rst = 1'b0;
    set_ctl(1'b1, 1'b1);
    tick();
    check("run_pc4", pc, 32'h4);
    check("run_i1", instr, 32'h2002_0002);
    tick();
    check("run_pc8", pc, 32'h8);

    set_ctl(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("step0_pc", pc, 32'h8);
      check("step0_i", instr, 32'h2003_0003);
    end
    set_ctl(1'b1, 1'b1);
    tick();
    check("step1_pc", pc, 32'hC);
    check("halt_word", instr, 32'hFFFF_FFFF);

    set_ctl(1'b0, 1'b1);
    tick();
    check("stall_halt_pc", pc, 32'hC);
    check("stall_halt_h", {31'b0, halted}, 32'h0);

    set_ctl(1'b1, 1'b1);
    tick();
    check("halt_pc", pc, 32'h10);
    check("halt_h", {31'b0, halted}, 32'h1);
    check("halt_nop", instr, 32'h0);
    @(negedge clk);
    br = 1'b1;
    br_addr = 32'hC0;
    tick();
    tick();
    check("halt_hold", pc, 32'h10);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_h", {31'b0, halted}, 32'h0);
    check("arst_i", instr, 32'h2001_0001);
    @(negedge clk);
    rst = 1'b0;

    set_ctl(1'b1, 1'b1);
    jr = 1'b1;
    jr_addr = 32'h40;
    jmp = 1'b1;
    jmp_addr = 32'h80;
    br = 1'b1;
    br_addr = 32'hC0;
    tick();
    check("prio_jr", pc, 32'h40);
    @(negedge clk);
    jr = 1'b0;
    tick();
    check("prio_j", pc, 32'h80);
    @(negedge clk);
    jmp = 1'b0;
    pc_wr = 1'b0;
    tick();
    check("stall_br", pc, 32'h80);
    @(negedge clk);
    pc_wr = 1'b1;
    tick();
    check("br", pc, 32'hC0);
    check("br_i", instr, 32'd48);

    set_ctl(1'b1, 1'b1);
    jr = 1'b1;
    jr_addr = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4, 32'h0);
    check("wrap_pc8", pc8, 32'h4);
    check("wrap_i", instr, 32'hDEAD_BEEF);
    set_ctl(1'b1, 1'b1);
    tick();
    check("wrap_seq", pc, 32'h0);

    set_ctl(1'b1, 1'b1);
    jr = 1'b1;
    jr_addr = 32'h0000_0406;
    tick();
    check("idx_wrap_i", instr, 32'h2002_0002);

    set_ctl(1'b1, 1'b1);
    jr = 1'b1;
    jr_addr = 32'h8;
    tick();
    check("pre_wr_i", instr, 32'h2003_0003);
    set_ctl(1'b1, 1'b0);
    mem_wr(8'd2, 32'h1234_5678);
    check("wr_rd_pc", pc, 32'h8);
    check("wr_rd_i", instr, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
